// File: rtl/median_filter_ctrl.sv
// Streaming 2x2 RGB median filter: one-row line buffer, per-channel median of each
// complete window, registered valid/ready output with a single-cycle latency.
module median_filter_ctrl #(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned PIXEL_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s_valid_i,
    output logic                   s_ready_o,
    input  logic [3*PIXEL_W-1:0]   s_pixel_i,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic [3*PIXEL_W-1:0]   m_pixel_o,
    output logic                   m_last_o,
    output logic                   frame_done_o
);

    localparam int unsigned PixW = 3 * PIXEL_W;
    localparam int unsigned ColW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int unsigned RowW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [ColW-1:0] ColLast = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] RowLast = RowW'(IMG_H - 1);

    typedef enum logic [0:0] {StFill, StStream} state_e;

    state_e            state_q, state_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [RowW-1:0]   row_q, row_d;
    logic [PixW-1:0]   prev_cur_q, prev_cur_d;
    logic [PixW-1:0]   prev_up_q, prev_up_d;
    logic              m_valid_q, m_valid_d;
    logic [PixW-1:0]   m_pixel_q, m_pixel_d;
    logic              m_last_q, m_last_d;
    logic              frame_done_q, frame_done_d;
    logic [PixW-1:0]   line_q [IMG_W];

    logic              in_xfer;
    logic              col_last;
    logic              row_last;
    logic [PixW-1:0]   up;
    logic [PixW-1:0]   med;

    // Five-comparator sort; only the middle pair is needed, averaged without wrap.
    function automatic logic [PIXEL_W-1:0] med4(input logic [PIXEL_W-1:0] p0,
                                                input logic [PIXEL_W-1:0] p1,
                                                input logic [PIXEL_W-1:0] p2,
                                                input logic [PIXEL_W-1:0] p3);
        logic [PIXEL_W-1:0] s0, s1, s2, s3, t1, t2, m1, m2;
        logic [PIXEL_W:0]   sum;
        s0  = (p0 < p1) ? p0 : p1;
        s1  = (p0 < p1) ? p1 : p0;
        s2  = (p2 < p3) ? p2 : p3;
        s3  = (p2 < p3) ? p3 : p2;
        t2  = (s0 < s2) ? s2 : s0;
        t1  = (s1 < s3) ? s1 : s3;
        m1  = (t1 < t2) ? t1 : t2;
        m2  = (t1 < t2) ? t2 : t1;
        sum = {1'b0, m1} + {1'b0, m2};
        return sum[PIXEL_W:1];
    endfunction

    assign s_ready_o    = !m_valid_q || m_ready_i;
    assign in_xfer      = s_valid_i && s_ready_o;
    assign col_last     = (col_q == ColLast);
    assign row_last     = (row_q == RowLast);
    assign up           = line_q[col_q];
    assign m_valid_o    = m_valid_q;
    assign m_pixel_o    = m_pixel_q;
    assign m_last_o     = m_last_q;
    assign frame_done_o = frame_done_q;

    always_comb begin
        med = '0;
        for (int ch = 0; ch < 3; ch++) begin
            med[ch*PIXEL_W +: PIXEL_W] = med4(prev_up_q[ch*PIXEL_W +: PIXEL_W],
                                              up[ch*PIXEL_W +: PIXEL_W],
                                              prev_cur_q[ch*PIXEL_W +: PIXEL_W],
                                              s_pixel_i[ch*PIXEL_W +: PIXEL_W]);
        end
    end

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        prev_cur_d   = prev_cur_q;
        prev_up_d    = prev_up_q;
        frame_done_d = 1'b0;
        m_valid_d    = m_valid_q && !m_ready_i;
        m_pixel_d    = m_pixel_q;
        m_last_d     = m_valid_d ? m_last_q : 1'b0;

        if (in_xfer) begin
            prev_cur_d   = s_pixel_i;
            prev_up_d    = up;
            frame_done_d = col_last && row_last;
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            unique case (state_q)
                StFill: begin
                    if (col_last) begin
                        state_d = StStream;
                    end
                end
                StStream: begin
                    // Column 0 only primes the window registers.
                    if (col_q != '0) begin
                        m_valid_d = 1'b1;
                        m_pixel_d = med;
                        m_last_d  = col_last && row_last;
                    end
                    if (col_last && row_last) begin
                        state_d = StFill;
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StFill;
            col_q        <= '0;
            row_q        <= '0;
            prev_cur_q   <= '0;
            prev_up_q    <= '0;
            m_valid_q    <= 1'b0;
            m_pixel_q    <= '0;
            m_last_q     <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            prev_cur_q   <= prev_cur_d;
            prev_up_q    <= prev_up_d;
            m_valid_q    <= m_valid_d;
            m_pixel_q    <= m_pixel_d;
            m_last_q     <= m_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Read of line_q[col_q] above sees the old row because the write lands at the edge.
    always_ff @(posedge clk_i) begin
        if (in_xfer) begin
            line_q[col_q] <= s_pixel_i;
        end
    end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Directed and randomized bench for median_filter_ctrl on a 4x3 frame, scored against
// a frame-array reference model with sorted-median arithmetic.
module tb_median_filter_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int OUTS = (W - 1) * (H - 1);

    typedef struct packed {
        logic [23:0] px;
        logic        last;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_pixel;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_pixel;
    logic        m_last;
    logic        frame_done;

    int          checks = 0;
    int          failures = 0;
    out_t        exp_q[$];
    logic [23:0] img [H][W];
    int          mrow = 0;
    int          mcol = 0;
    logic        exp_fd = 1'b0;
    int          fd_seen = 0;
    int          outs = 0;
    logic        accepted;

    median_filter_ctrl #(
        .IMG_W   (W),
        .IMG_H   (H),
        .PIXEL_W (8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .s_valid_i    (s_valid),
        .s_ready_o    (s_ready),
        .s_pixel_i    (s_pixel),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_pixel_o    (m_pixel),
        .m_last_o     (m_last),
        .frame_done_o (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] ref_med(input logic [23:0] a, input logic [23:0] b,
                                            input logic [23:0] c, input logic [23:0] d);
        logic [23:0] r;
        int v[$];
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            v.delete();
            v.push_back(int'(a[ch*8 +: 8]));
            v.push_back(int'(b[ch*8 +: 8]));
            v.push_back(int'(c[ch*8 +: 8]));
            v.push_back(int'(d[ch*8 +: 8]));
            v.sort();
            r[ch*8 +: 8] = 8'((v[1] + v[2]) / 2);
        end
        return r;
    endfunction

    task automatic model_in(input logic [23:0] px);
        out_t o;
        logic is_last;
        img[mrow][mcol] = px;
        is_last = (mrow == H - 1) && (mcol == W - 1);
        if (mrow >= 1 && mcol >= 1) begin
            o.px   = ref_med(img[mrow-1][mcol-1], img[mrow-1][mcol], img[mrow][mcol-1], px);
            o.last = is_last;
            exp_q.push_back(o);
        end
        if (is_last) exp_fd = 1'b1;
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
        end
    endtask

    task automatic step(input logic sv, input logic [23:0] px, input logic mr, input logic rn);
        logic ev;
        logic esr;
        s_valid = sv;
        s_pixel = px;
        m_ready = mr;
        rst_n   = rn;
        accepted = 1'b0;
        @(negedge clk);
        ev  = (exp_q.size() != 0);
        esr = !ev || mr;
        chk("m_valid", {31'd0, m_valid}, {31'd0, ev});
        chk("s_ready", {31'd0, s_ready}, {31'd0, esr});
        chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
        if (ev) begin
            chk("m_pixel", {8'd0, m_pixel}, {8'd0, exp_q[0].px});
            chk("m_last", {31'd0, m_last}, {31'd0, exp_q[0].last});
        end
        if (frame_done === 1'b1) fd_seen++;
        if (m_valid === 1'b1 && mr) begin
            outs++;
            if (m_last === 1'b1) begin
                chk("outs_per_frame", outs, OUTS);
                outs = 0;
            end
        end
        if (!rn) begin
            exp_q.delete();
            mrow   = 0;
            mcol   = 0;
            exp_fd = 1'b0;
            outs   = 0;
        end else begin
            exp_fd = 1'b0;
            if (ev && mr) void'(exp_q.pop_front());
            if (sv && esr) begin
                model_in(px);
                accepted = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] ramp(input int i);
        logic [7:0] v;
        v = 8'((i % W) + 4 * (i / W));
        return {v, v, v};
    endfunction

    initial begin
        logic [23:0] win [12];
        int fed;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_pixel = '0;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_m_pixel", {8'd0, m_pixel}, 32'd0);
        chk("rst_m_last", {31'd0, m_last}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);

        // Ramp frame, no backpressure.
        fd_seen = 0;
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, ramp(i), 1'b1, 1'b1);
            if (i == 5) chk("first_out", {8'd0, m_pixel}, 32'h020202);
        end
        repeat (2) step(1'b0, '0, 1'b1, 1'b1);
        chk("fd_pulses_ramp", fd_seen, 1);

        // Single high-valued red window: no overflow in the middle-pair sum.
        for (int i = 0; i < 12; i++) win[i] = '0;
        win[0] = {8'd200, 16'd0};
        win[1] = {8'd250, 16'd0};
        win[4] = {8'd255, 16'd0};
        win[5] = {8'd240, 16'd0};
        for (int i = 0; i < W * H; i++) begin
            step(1'b1, win[i], 1'b1, 1'b1);
            if (i == 5) chk("red_245", {8'd0, m_pixel}, {8'd0, 8'd245, 16'd0});
        end
        repeat (2) step(1'b0, '0, 1'b1, 1'b1);

        // Ramp frame with a 10-cycle stall at row 1, col 2.
        for (int i = 0; i < W * H; i++) begin
            if (i == 6) begin
                repeat (10) begin
                    step(1'b1, ramp(6), 1'b0, 1'b1);
                    chk("stall_hold", {8'd0, m_pixel}, 32'h020202);
                end
            end
            step(1'b1, ramp(i), 1'b1, 1'b1);
        end
        repeat (2) step(1'b0, '0, 1'b1, 1'b1);

        // Partial frame, then reset at row 1, col 2.
        for (int i = 0; i < 6; i++) step(1'b1, 24'($urandom), 1'b1, 1'b1);
        step(1'b1, 24'($urandom), 1'b1, 1'b0);
        chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);

        // Three back-to-back random frames with gaps and backpressure.
        fd_seen = 0;
        fed = 0;
        for (int n = 0; n < 2000 && fed < 3 * W * H; n++) begin
            step(1'($urandom % 2), 24'($urandom), 1'($urandom % 2), 1'b1);
            if (accepted) fed++;
        end
        chk("random_progress", fed, 3 * W * H);
        repeat (4) step(1'b0, '0, 1'b1, 1'b1);
        chk("fd_pulses_random", fd_seen, 3);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/median_filter_ctrl.md
Name: median_filter_ctrl

Overview:
- Streaming sequencer for the 2x2 RGB median filter.
- Accepts pixels in raster order over a valid/ready stream and keeps one row of history in an internal line buffer.
- For each complete 2x2 window, computes the per-channel median (mean of the middle two of four sorted values) and emits one filtered pixel over a registered valid/ready output.
- Sits between the pixel source (camera/DMA) and the downstream frame sink; output frame is (IMG_W-1) x (IMG_H-1).

Parameters:
- IMG_W, 640, pixels per row; minimum 2.
- IMG_H, 480, rows per frame; minimum 2.
- PIXEL_W, 8, bits per colour channel; pixel word is 3*PIXEL_W, packed {red, green, blue}.

Ports:
- clk, in, 1, single clock; all logic on rising edge.
- rst_n, in, 1, synchronous active-low reset.
- s_valid, in, 1, input pixel valid.
- s_ready, out, 1, block can accept an input pixel.
- s_pixel, in, 3*PIXEL_W, input pixel {r,g,b}.
- m_valid, out, 1, output pixel valid.
- m_ready, in, 1, downstream accepts output.
- m_pixel, out, 3*PIXEL_W, filtered pixel {r,g,b}.
- m_last, out, 1, qualifies the final output pixel of a frame.
- frame_done, out, 1, one-cycle pulse when the last input pixel of a frame is accepted.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - m_valid, m_pixel, m_last, frame_done are all 0.
  - col=0, row=0, state=FILL.
  - Line buffer contents are don't-care; row 0 always rewrites them.
- Handshake:
  - Input transfer occurs when s_valid && s_ready.
  - Output transfer occurs when m_valid && m_ready.
  - s_ready = !m_valid || m_ready. This is a single output register with no skid; s_ready is combinational from m_ready.
  - m_pixel and m_last are held stable while m_valid && !m_ready.
- Counters (advance only on input transfer):
  - col increments from 0 to IMG_W-1.
  - On col==IMG_W-1: col wraps to 0 and row increments.
  - On row==IMG_H-1 && col==IMG_W-1: row wraps to 0 and frame_done pulses for exactly one cycle, on the cycle after the transfer.
- Line buffer:
  - IMG_W entries of 3*PIXEL_W.
  - On each input transfer: read entry[col] (previous row, same column), then write s_pixel to entry[col]. Read-before-write is required.
  - Registers prev_cur (current row, col-1) and prev_up (previous row, col-1) update on every input transfer.
- Window at transfer with col>=1 and row>=1: {prev_up, up=buf[col], prev_cur, s_pixel}.
- States:
  - FILL: row==0. Pixels are stored only; no output.
  - STREAM: row>=1. Output is produced when col>=1.
  - FILL->STREAM when row 0 completes.
  - STREAM->FILL when the frame wraps.
  - col==0 transfers in STREAM produce no output; they only prime prev_cur/prev_up.
- Arithmetic, per channel, independently:
  - Sort the four values with the 5-comparator network (a,b),(c,d),(a,c),(b,d),(b,c).
  - Take the middle pair m1<=m2.
  - Result = (m1+m2)>>1, with the sum computed in PIXEL_W+1 bits (no wrap; floor).
- Latency: 1 cycle. An input transfer at edge N that completes a window sets m_valid at edge N with the result, visible in cycle N+1.
- m_last = 1 with the output for row==IMG_H-1, col==IMG_W-1.
- Simultaneous events:
  - An output accepted and a new window arriving on the same edge: m_valid stays 1 with the new data.
  - An output accepted with no new window: m_valid falls to 0.
- Backpressure: with m_ready=0 and m_valid=1, s_ready=0 and no input is consumed, so the counters freeze.
- Reset mid-frame: the partial frame is discarded, any pending output is dropped, and the next accepted pixel is treated as (0,0).

Test Plan:
- IMG_W=4, IMG_H=3, all channels = col+4*row, m_ready=1 -> exactly 6 outputs; the first is R=G=B=(1+4)>>1=2 (middles 1,4; floor 2.5); m_last only on the 6th; frame_done pulses once.
- Single window {200,250,255,240} on red, 0 elsewhere -> red=(240+250)>>1=245, no 8-bit overflow; green=blue=0.
- Hold m_ready=0 for 10 cycles mid-row with s_valid=1 -> s_ready=0, m_pixel stable, counters unchanged; resume -> output sequence identical to the unstalled run.
- Random s_valid gaps (50%) and m_ready toggling over 3 back-to-back frames -> outputs match the golden model bit-exactly; 6 outputs per frame; row-0 data never emitted.
- rst_n low for 1 cycle at row 1, col 2 -> m_valid=0 next cycle; the following full frame is correct, with no stale-row contamination.
- First column of each row (col==0, row>=1) -> no output produced; the column count per output row is IMG_W-1.
